sevenseg_capture: RTL and testbench



---
 rtl/sevenseg_pkg.sv | 32 +++
 rtl/sevenseg_decode.sv | 37 +++
 rtl/sevenseg_capture.sv | 168 ++++++++++++++++
 tb/tb_sevenseg_capture.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sevenseg_pkg.sv
// Shared types and the active-low hex font (bit 0 = segment a .. bit 6 = segment g)
// for the seven-segment capture block.
package sevenseg_pkg;

    typedef logic [6:0] seg_t;
    typedef logic [3:0] nibble_t;

    typedef enum logic [1:0] {
        ST_WAIT     = 2'd0,
        ST_SETTLE   = 2'd1,
        ST_CAPTURED = 2'd2
    } scan_state_t;

    localparam seg_t SEG_0     = 7'b1000000;
    localparam seg_t SEG_1     = 7'b1111001;
    localparam seg_t SEG_2     = 7'b0100100;
    localparam seg_t SEG_3     = 7'b0110000;
    localparam seg_t SEG_4     = 7'b0011001;
    localparam seg_t SEG_5     = 7'b0010010;
    localparam seg_t SEG_6     = 7'b0000010;
    localparam seg_t SEG_7     = 7'b1111000;
    localparam seg_t SEG_8     = 7'b0000000;
    localparam seg_t SEG_9     = 7'b0010000;
    localparam seg_t SEG_A     = 7'b0001000;
    localparam seg_t SEG_B     = 7'b0000011;
    localparam seg_t SEG_C     = 7'b1000110;
    localparam seg_t SEG_D     = 7'b0100001;
    localparam seg_t SEG_E     = 7'b0000110;
    localparam seg_t SEG_F     = 7'b0001110;
    localparam seg_t SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/sevenseg_decode.sv
// Inverse of the hex font: maps an active-low glyph back to its nibble,
// flagging anything outside the font (blank included) as invalid.
module sevenseg_decode
    import sevenseg_pkg::*;
(
    input  seg_t    seg,
    output nibble_t nibble,
    output logic    valid
);

    // Glyph lookup; unknown patterns decode to zero with valid low
    always_comb begin
        nibble = 4'h0;
        valid  = 1'b1;
        case (seg)
            SEG_0:     nibble = 4'h0;
            SEG_1:     nibble = 4'h1;
            SEG_2:     nibble = 4'h2;
            SEG_3:     nibble = 4'h3;
            SEG_4:     nibble = 4'h4;
            SEG_5:     nibble = 4'h5;
            SEG_6:     nibble = 4'h6;
            SEG_7:     nibble = 4'h7;
            SEG_8:     nibble = 4'h8;
            SEG_9:     nibble = 4'h9;
            SEG_A:     nibble = 4'hA;
            SEG_B:     nibble = 4'hB;
            SEG_C:     nibble = 4'hC;
            SEG_D:     nibble = 4'hD;
            SEG_E:     nibble = 4'hE;
            SEG_F:     nibble = 4'hF;
            SEG_BLANK: valid  = 1'b0;
            default:   valid  = 1'b0;
        endcase
    end

endmodule

// File: rtl/sevenseg_capture.sv
// Reads a multiplexed active-low seven-segment bus back into a hex value and
// presents each completed multi-digit frame on a valid/ready interface.
module sevenseg_capture
    import sevenseg_pkg::*;
#(
    parameter  int NDIGITS       = 4,
    parameter  int STABLE_CYCLES = 8,
    localparam int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
    input  logic                   clock,
    input  logic                   n_reset,
    input  seg_t                   seg,
    input  logic [NDIGITS-1:0]     an,
    output logic [4*NDIGITS-1:0]   value,
    output logic [NDIGITS-1:0]     digit_err,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   overrun
);

    seg_t                  seg_meta_r, seg_sync_r;
    logic [NDIGITS-1:0]    an_meta_r, an_sync_r;
    logic [NDIGITS+6:0]    pair_prev_r;
    logic [CNT_W-1:0]      cnt_r;
    scan_state_t           st_r;
    logic [NDIGITS-1:0]    seen_r;
    logic [4*NDIGITS-1:0]  slot_val_r;
    logic [NDIGITS-1:0]    slot_err_r;
    logic [4*NDIGITS-1:0]  value_r;
    logic [NDIGITS-1:0]    digit_err_r;
    logic                  out_valid_r;
    logic                  overrun_r;

    logic [NDIGITS+6:0]    pair_s;
    logic                  same_s;
    logic                  reach_s;
    logic                  one_cold_s;
    logic [NDIGITS-1:0]    low_s;
    logic [CNT_W-1:0]      cnt_next_s;
    scan_state_t           st_next_s;
    logic                  capture_s;
    logic [NDIGITS-1:0]    cap_mask_s;
    logic                  frame_done_s;
    nibble_t               dec_nib_s;
    logic                  dec_ok_s;

    sevenseg_decode u_decode (
        .seg    (seg_sync_r),
        .nibble (dec_nib_s),
        .valid  (dec_ok_s)
    );

    // Two-flop synchronizers for the asynchronous display lines
    always_ff @(posedge clock) begin
        if (!n_reset) begin
            seg_meta_r <= 7'd0;
            seg_sync_r <= 7'd0;
            an_meta_r  <= '0;
            an_sync_r  <= '0;
        end else begin
            seg_meta_r <= seg;
            seg_sync_r <= seg_meta_r;
            an_meta_r  <= an;
            an_sync_r  <= an_meta_r;
        end
    end

    // Stability tracking of the synchronized {an, seg} pair
    always_comb begin
        pair_s     = {an_sync_r, seg_sync_r};
        same_s     = (pair_s == pair_prev_r);
        low_s      = ~an_sync_r;
        one_cold_s = (low_s != '0) && ((low_s & (low_s - NDIGITS'(1))) == '0);
        reach_s    = same_s && (cnt_r == CNT_W'(STABLE_CYCLES - 1));
        if (!same_s) begin
            cnt_next_s = CNT_W'(1);
        end else if (cnt_r == CNT_W'(STABLE_CYCLES)) begin
            cnt_next_s = cnt_r;
        end else begin
            cnt_next_s = cnt_r + CNT_W'(1);
        end
    end

    // Scan-slot state machine; capture fires on the transition into CAPTURED only
    always_comb begin
        st_next_s  = st_r;
        capture_s  = 1'b0;
        case (st_r)
            ST_WAIT, ST_SETTLE: begin
                if (!one_cold_s) begin
                    st_next_s = ST_WAIT;
                end else if (reach_s) begin
                    st_next_s = ST_CAPTURED;
                    capture_s = 1'b1;
                end else begin
                    st_next_s = ST_SETTLE;
                end
            end
            ST_CAPTURED: begin
                if (same_s) begin
                    st_next_s = ST_CAPTURED;
                end else if (!one_cold_s) begin
                    st_next_s = ST_WAIT;
                end else begin
                    st_next_s = ST_SETTLE;
                end
            end
            default: st_next_s = ST_WAIT;
        endcase
        cap_mask_s   = capture_s ? low_s : '0;
        frame_done_s = &seen_r;
    end

    // Counter, previous pair and FSM state registers
    always_ff @(posedge clock) begin
        if (!n_reset) begin
            pair_prev_r <= '0;
            cnt_r       <= '0;
            st_r        <= ST_WAIT;
        end else begin
            pair_prev_r <= pair_s;
            cnt_r       <= cnt_next_s;
            st_r        <= st_next_s;
        end
    end

    // Slot storage; a capture and a frame completion never share a cycle
    always_ff @(posedge clock) begin
        if (!n_reset) begin
            seen_r     <= '0;
            slot_val_r <= '0;
            slot_err_r <= '0;
        end else begin
            seen_r <= (frame_done_s ? '0 : seen_r) | cap_mask_s;
            for (int k = 0; k < NDIGITS; k++) begin
                if (cap_mask_s[k]) begin
                    slot_val_r[4*k +: 4] <= dec_nib_s;
                    slot_err_r[k]        <= ~dec_ok_s;
                end
            end
        end
    end

    // Output frame register and handshake; overrun is sticky until reset
    always_ff @(posedge clock) begin
        if (!n_reset) begin
            value_r     <= '0;
            digit_err_r <= '0;
            out_valid_r <= 1'b0;
            overrun_r   <= 1'b0;
        end else if (frame_done_s) begin
            value_r     <= slot_val_r;
            digit_err_r <= slot_err_r;
            out_valid_r <= 1'b1;
            if (out_valid_r && !out_ready) begin
                overrun_r <= 1'b1;
            end
        end else if (out_valid_r && out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    assign value     = value_r;
    assign digit_err = digit_err_r;
    assign out_valid = out_valid_r;
    assign overrun   = overrun_r;

endmodule

// File: tb/tb_sevenseg_capture.sv
// Self-checking bench: directed scans plus random scans, compared every cycle
// against a history-based model of glyph capture and frame delivery.
module tb_sevenseg_capture;

    localparam int ND   = 4;
    localparam int S    = 8;
    localparam int HMAX = 8000;

    logic            clock = 1'b0;
    logic            n_reset;
    logic [6:0]      seg;
    logic [ND-1:0]   an;
    logic            out_ready;
    logic [4*ND-1:0] value;
    logic [ND-1:0]   digit_err;
    logic            out_valid;
    logic            overrun;

    sevenseg_capture #(.NDIGITS(ND), .STABLE_CYCLES(S)) dut (
        .clock     (clock),
        .n_reset   (n_reset),
        .seg       (seg),
        .an        (an),
        .value     (value),
        .digit_err (digit_err),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overrun   (overrun)
    );

    always #5 clock = ~clock;

    logic [6:0] font [0:15] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    int          cyc = 0;
    int          hist_start = 1;
    logic [10:0] hist [0:HMAX-1];
    logic [15:0] m_slots, m_value;
    logic [3:0]  m_slot_err, m_err, m_seen;
    logic        m_valid, m_overrun;

    // observation of delivered frames
    logic        prev_valid = 1'b0;
    int          rises = 0;
    int          rise_cyc = 0;
    logic [15:0] last_val = 16'h0;
    logic [3:0]  last_err = 4'h0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic void font_lookup(input logic [6:0] g, output logic [3:0] nib, output logic ok);
        nib = 4'h0;
        ok  = 1'b0;
        for (int i = 15; i >= 0; i--) begin
            if (font[i] == g) begin
                nib = 4'(i);
                ok  = 1'b1;
            end
        end
    endfunction

    // A digit is captured at edge n when the synchronized sample (input of edge n-2)
    // has just completed a run of exactly S identical samples.
    function automatic bit run_completes(input int n);
        int first;
        first = n - 1 - S;
        if (first < hist_start) return 1'b0;
        for (int i = first; i < n - 1; i++) begin
            if (hist[i] !== hist[n-2]) return 1'b0;
        end
        if (first - 1 >= hist_start && hist[first-1] === hist[first]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_edge(input logic rdy, input logic rst_n);
        logic [3:0] a, nib;
        logic       ok;
        if (!rst_n) begin
            m_slots = 16'h0; m_slot_err = 4'h0; m_seen = 4'h0;
            m_value = 16'h0; m_err = 4'h0; m_valid = 1'b0; m_overrun = 1'b0;
            hist_start = cyc + 1;
        end else begin
            if (m_seen == 4'hF) begin
                if (m_valid && !rdy) m_overrun = 1'b1;
                m_value = m_slots;
                m_err   = m_slot_err;
                m_valid = 1'b1;
                m_seen  = 4'h0;
            end else if (m_valid && rdy) begin
                m_valid = 1'b0;
            end
            if (run_completes(cyc)) begin
                a = hist[cyc-2][10:7];
                if ($countones(~a) == 1) begin
                    font_lookup(hist[cyc-2][6:0], nib, ok);
                    for (int k = 0; k < ND; k++) begin
                        if (!a[k]) begin
                            m_slots[4*k +: 4] = nib;
                            m_slot_err[k]     = ~ok;
                            m_seen[k]         = 1'b1;
                        end
                    end
                end
            end
        end
    endtask

    task automatic step(input logic [3:0] a, input logic [6:0] s, input logic rdy, input logic rst_n);
        an = a; seg = s; out_ready = rdy; n_reset = rst_n;
        @(posedge clock);
        #1;
        cyc++;
        if (cyc >= HMAX) begin
            $display("FAIL cycle_budget: got %0d expected below %0d", cyc, HMAX);
            $fatal(1, "cycle budget exhausted");
        end
        hist[cyc] = {a, s};
        model_edge(rdy, rst_n);
        check_eq("value", value, m_value);
        check_eq("digit_err", digit_err, m_err);
        check_eq("out_valid", out_valid, m_valid);
        check_eq("overrun", overrun, m_overrun);
        if (out_valid === 1'b1 && !prev_valid) begin
            rises++;
            rise_cyc = cyc;
            last_val = value;
            last_err = digit_err;
        end
        prev_valid = (out_valid === 1'b1);
    endtask

    task automatic show(input int k, input logic [6:0] g, input int hold, input logic rdy);
        for (int i = 0; i < hold; i++) step(~(4'b0001 << k), g, rdy, 1'b1);
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(4'hF, 7'h7F, rdy, 1'b1);
    endtask

    task automatic frame(input logic [15:0] v, input int hold, input logic rdy);
        for (int k = 0; k < ND; k++) show(k, font[v[4*k +: 4]], hold, rdy);
    endtask

    initial begin
        int r0, g;
        logic [6:0] glyph;
        logic [3:0] a;

        for (int i = 0; i < 3; i++) step(4'hF, 7'h7F, 1'b1, 1'b0);
        check_eq("rst_value", value, 32'h0);
        check_eq("rst_valid", out_valid, 32'h0);
        check_eq("rst_overrun", overrun, 32'h0);
        idle(4, 1'b1);

        // basic frame 4321
        r0 = rises;
        frame(16'h4321, 20, 1'b1);
        idle(10, 1'b1);
        check_eq("t1_pulses", rises - r0, 1);
        check_eq("t1_value", last_val, 32'h4321);
        check_eq("t1_err", last_err, 32'h0);
        check_eq("t1_valid_low", out_valid, 32'h0);

        // holds shorter than the stability window never capture
        r0 = rises;
        show(0, font[15], 5, 1'b1);
        show(1, font[14], 5, 1'b1);
        show(2, font[13], 5, 1'b1);
        show(3, font[12], 5, 1'b1);
        idle(20, 1'b1);
        check_eq("t2_no_frame", rises - r0, 0);
        check_eq("t2_valid", out_valid, 32'h0);

        // blank digit 2
        r0 = rises;
        show(0, font[0], 20, 1'b1);
        show(1, font[0], 20, 1'b1);
        show(2, 7'h7F, 20, 1'b1);
        show(3, font[0], 20, 1'b1);
        idle(10, 1'b1);
        check_eq("t3_pulses", rises - r0, 1);
        check_eq("t3_value", last_val, 32'h0);
        check_eq("t3_err", last_err, 32'h4);

        // two frames with the consumer stalled
        frame(16'h1234, 20, 1'b0);
        frame(16'hABCD, 20, 1'b0);
        idle(5, 1'b0);
        check_eq("t4_value", value, 32'hABCD);
        check_eq("t4_valid", out_valid, 32'h1);
        check_eq("t4_overrun", overrun, 32'h1);
        idle(1, 1'b1);
        check_eq("t4_accept", out_valid, 32'h0);
        check_eq("t4_overrun_sticky", overrun, 32'h1);

        // reset mid-frame discards the partial frame
        show(2, font[5], 20, 1'b1);
        show(3, font[5], 20, 1'b1);
        step(4'hF, 7'h7F, 1'b1, 1'b0);
        check_eq("t5_rst_value", value, 32'h0);
        check_eq("t5_rst_err", digit_err, 32'h0);
        check_eq("t5_rst_valid", out_valid, 32'h0);
        check_eq("t5_rst_overrun", overrun, 32'h0);
        r0 = rises;
        show(0, font[0], 20, 1'b1);
        show(1, font[8], 20, 1'b1);
        idle(10, 1'b1);
        check_eq("t5_partial", rises - r0, 0);
        show(2, font[11], 20, 1'b1);
        show(3, font[0], 20, 1'b1);
        idle(10, 1'b1);
        check_eq("t5_pulses", rises - r0, 1);
        check_eq("t5_value", last_val, 32'h0B80);

        // two enables low, then a one-cycle segment glitch
        r0 = rises;
        for (int i = 0; i < 50; i++) step(4'b1100, font[3], 1'b1, 1'b1);
        idle(5, 1'b1);
        check_eq("t6_multi_low", rises - r0, 0);
        show(0, font[1], 20, 1'b1);
        show(1, font[1], 20, 1'b1);
        show(2, font[1], 20, 1'b1);
        check_eq("t6_three_digits", rises - r0, 0);
        show(3, font[7], 5, 1'b1);
        glyph = font[7] ^ 7'b0000001;
        show(3, glyph, 1, 1'b1);
        g = cyc + 1;
        show(3, font[7], 20, 1'b1);
        idle(5, 1'b1);
        check_eq("t6_pulses", rises - r0, 1);
        check_eq("t6_value", last_val, 32'h7111);
        check_eq("t6_latency", rise_cyc, g + 2 + S);

        // random scans
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 19) == 0) step(4'hF, 7'h7F, 1'b1, 1'b0);
            for (int d = 0; d < 5; d++) begin
                if ($urandom_range(0, 9) == 0) glyph = 7'($urandom);
                else glyph = font[$urandom_range(0, 15)];
                if ($urandom_range(0, 9) == 0) a = 4'($urandom);
                else a = ~(4'b0001 << $urandom_range(0, 3));
                for (int h = $urandom_range(3, 14); h > 0; h--) begin
                    step(a, glyph, ($urandom_range(0, 3) != 0), 1'b1);
                end
            end
            for (int h = $urandom_range(0, 3); h > 0; h--) step(4'hF, 7'h7F, ($urandom_range(0, 1) != 0), 1'b1);
        end
        idle(15, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
